fetch_writeback: RTL
====================

FETCH_WRITEBACK -- requirements
Module: fetch_writeback

Interface
REQ-001 Parameter: IM_AW, 8, instruction-memory word-address width; im_addr = pc[IM_AW-1:0].
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstd  input  1  asynchronous, active-low reset.
REQ-004 Port: im_addr  output  IM_AW  instruction-memory read address; memory registers it on clk and returns data one cycle later.
REQ-005 Port: im_data  input  32  instruction word from instruction memory.
REQ-006 Port: ins  output  32  registered current instruction, to execute stage.
REQ-007 Port: pc  output  32  registered program counter, word-addressed, to execute stage.
REQ-008 Port: reg1  output  32  registered value of rf[ins[25:21]].
REQ-009 Port: reg2  output  32  registered value of rf[ins[20:16]].
REQ-010 Port: wra  input  5  write-back register index from execute stage.
REQ-011 Port: result  input  32  write-back data from execute stage.
REQ-012 Port: nextpc  input  32  next PC from execute stage.
REQ-013 Port: retired  output  1  one-cycle pulse in the WB cycle of each instruction.
REQ-014 Port: icount  output  32  retired-instruction counter.
REQ-015 Port: halted  output  1  high while sequencer is in HALT.

Function
REQ-016 Sequencer SHALL cycle FETCH -> DECODE -> EXEC -> WB -> FETCH, one clock per state; one instruction per 4 cycles.
REQ-017 FETCH: im_addr driven from pc; ins, reg1, reg2 hold previous values.
REQ-018 DECODE: ins <= im_data; reg1/reg2 <= rf[im_data[25:21]]/rf[im_data[20:16]], read from im_data, not old ins.
REQ-019 Register 0 SHALL read as 0 regardless of writes.
REQ-020 EXEC: all outputs held so the execute stage's synchronous data-memory read completes and result settles.
REQ-021 WB: if wra != 0, rf[wra] <= result; pc <= nextpc; retired = 1; icount <= icount + 1.
REQ-022 Write to register 0 SHALL be discarded; other registers unaffected.
REQ-023 Value written in WB SHALL be visible in reg1/reg2 of the next instruction's DECODE (no forwarding needed).
REQ-024 pc and icount SHALL wrap modulo 2^32 without flags.
REQ-025 ins/reg1/reg2 SHALL stay constant from DECODE+1 through the following DECODE edge (stores may repeat identical writes; acceptable).

Reset
REQ-026 rstd low SHALL immediately force: state FETCH, pc 0, ins 0, reg1 0, reg2 0, all 32 registers 0, retired 0, icount 0, halted 0.
REQ-027 Reset asserted in any state, including WB, SHALL abort the instruction: no register write, no pc update.
REQ-028 First FETCH SHALL occur in the first clock cycle after rstd deasserts.

Configuration
REQ-029 Macro FETCH_WRITEBACK_HALT_EN: when defined, DECODE of op (im_data[31:26]) == 6'd63 SHALL enter HALT.
REQ-030 HALT with macro: pc, rf, icount frozen; retired 0; halted 1; exit only by reset.
REQ-031 Without macro: op 63 SHALL sequence normally through WB; halted tied to 0.

Verification
REQ-032 Reset release, im word 0: 0x04010005 (addi r1,r0,5) -> retired pulse in cycle 4, r1=5, pc=1, icount=1.
REQ-033 im 0: 0x04000007, im 1: 0x04020000 -> r0 stays 0, r2=0, pc=2, icount=2.
REQ-034 With execute stage attached, im 0: 0x80000003 (beq r0,r0,+3) -> pc=4 after WB; no register written.
REQ-035 im 0: 0xA4000010 (jal 0x10) -> pc=0x10, r31=1.
REQ-036 HALT_EN defined, im 0: 0xFC000000 -> halted=1 from cycle 3, pc=0, icount=0 for 20 cycles; undefined -> pc=1, icount=1.
REQ-037 addi r1,r0,5 with rstd pulsed low during EXEC -> r1=0, pc=0, icount=0; after release instruction re-executes, r1=5.

Source files
------------

// File: rtl/fetch_writeback.sv
// -----------------------------------------------------------------------------
// fetch_writeback
//   Four-phase instruction sequencer (FETCH -> DECODE -> EXEC -> WB) that owns
//   the program counter, the 32x32 register file and the retired-instruction
//   counter. The execute stage is external; it sees ins/pc/reg1/reg2 and hands
//   back wra/result/nextpc, which are committed in the WB cycle.
//
//   Optional feature (compile-time macro FETCH_WRITEBACK_HALT_EN):
//     when defined, an instruction with op (bits 31:26) == 63 parks the
//     sequencer in HALT after DECODE until reset. When undefined, op 63 is an
//     ordinary instruction and halted is tied low.
//
// Ports
//   clk      in   rising-edge clock
//   rstd     in   asynchronous active-low reset
//   im_addr  out  instruction-memory word address (pc[IM_AW-1:0]); the memory
//                 registers it, so im_data is valid in the following cycle
//   im_data  in   instruction word from instruction memory
//   ins      out  current instruction (latched in DECODE)
//   pc       out  word-addressed program counter
//   reg1     out  rf[rs] of the current instruction (latched in DECODE)
//   reg2     out  rf[rt] of the current instruction (latched in DECODE)
//   wra      in   write-back register index (0 = no write)
//   result   in   write-back data
//   nextpc   in   next program counter
//   retired  out  high for the WB cycle of each instruction
//   icount   out  retired-instruction counter (wraps)
//   halted   out  high while parked in HALT
// -----------------------------------------------------------------------------
module fetch_writeback #(
    parameter int IM_AW = 8
) (
    input  logic             clk,
    input  logic             rstd,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_data,
    output logic [31:0]      ins,
    output logic [31:0]      pc,
    output logic [31:0]      reg1,
    output logic [31:0]      reg2,
    input  logic [4:0]       wra,
    input  logic [31:0]      result,
    input  logic [31:0]      nextpc,
    output logic             retired,
    output logic [31:0]      icount,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Entry 0 is never written and is cleared by reset, so it always reads 0.
    logic [31:0][31:0] rf;

    // The memory registers this address at the end of FETCH.
    assign im_addr = pc[IM_AW-1:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH:  state_nxt = S_DECODE;
`ifdef FETCH_WRITEBACK_HALT_EN
            S_DECODE: state_nxt = (im_data[31:26] == 6'd63) ? S_HALT : S_EXEC;
`else
            S_DECODE: state_nxt = S_EXEC;
`endif
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;   // only reset leaves HALT
            default:  state_nxt = S_FETCH;
        endcase
    end

    // ---------------- state outputs ----------------
    always_comb begin
        retired = (state == S_WB);
`ifdef FETCH_WRITEBACK_HALT_EN
        halted  = (state == S_HALT);
`else
        halted  = 1'b0;
`endif
    end

    // ---------------- datapath ----------------
    // Operands are read using im_data directly (not the old ins), so a value
    // written in WB is already visible to the next instruction's DECODE.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            pc     <= '0;
            ins    <= '0;
            reg1   <= '0;
            reg2   <= '0;
            icount <= '0;
            rf     <= '0;
        end else begin
            if (state == S_DECODE) begin
                ins  <= im_data;
                reg1 <= rf[im_data[25:21]];
                reg2 <= rf[im_data[20:16]];
            end
            if (state == S_WB) begin
                if (wra != 5'd0) rf[wra] <= result;
                pc     <= nextpc;
                icount <= icount + 32'd1;
            end
        end
    end

endmodule
